// File: rtl/text_blitter.sv
// text_blitter: clear / scroll / fill engine for the 80x25 text-mode VRAM.
// One command at a time over valid/ready; every engine access is voided in
// any cycle the CPU claims the shared VRAM port (cpu_req), and retried.
module text_blitter #(
  parameter int COLS = 80,
  parameter int ROWS = 25
) (
  input  logic        CLK25,
  input  logic        RESET_N,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_line,
  input  logic [7:0]  cmd_char,
  input  logic [7:0]  cmd_attr,
  output logic        busy,
  output logic        done,
  input  logic        cpu_req,
  output logic [11:0] vram_address,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  input  logic [7:0]  vram_rdata
);

  localparam logic [11:0] LINE_BYTES   = 12'(2 * COLS);
  localparam logic [11:0] SCREEN_LAST  = 12'(2 * COLS * ROWS - 1);
  localparam logic [11:0] SCROLL_LAST  = 12'(2 * COLS * (ROWS - 1) - 1);
  localparam logic [4:0]  ROW_LIMIT    = 5'(ROWS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] OP_CLEAR  = 2'd0;
  localparam logic [1:0] OP_SCROLL = 2'd1;
  localparam logic [1:0] OP_FILL   = 2'd2;

  logic [2:0]  state;
  logic [11:0] idx;        // byte address currently being written
  logic [11:0] last_idx;   // final byte of the current fill phase
  logic [7:0]  fill_char;
  logic [7:0]  fill_attr;
  logic [7:0]  hold;       // byte copied from the row below, kept across WR stalls
  logic        wr_first;   // first WR cycle after a read: vram_rdata is live

  // 160*line computed as line*128 + line*32
  logic [11:0] line_base;
  assign line_base = {cmd_line, 7'b0} + {2'b0, cmd_line, 5'b0};

  // Control FSM, byte counter and latched command fields
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK25 or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      idx       <= '0;
      last_idx  <= '0;
      fill_char <= '0;
      fill_attr <= '0;
      hold      <= '0;
      wr_first  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            fill_char <= cmd_char;
            fill_attr <= cmd_attr;
            wr_first  <= 1'b0;
            case (cmd_op)
              OP_CLEAR: begin
                state    <= S_FILL;
                idx      <= '0;
                last_idx <= SCREEN_LAST;
              end
              OP_SCROLL: begin
                state    <= S_RD;
                idx      <= '0;
                last_idx <= SCREEN_LAST;
              end
              OP_FILL: begin
                if (cmd_line < ROW_LIMIT) begin
                  state    <= S_FILL;
                  idx      <= line_base;
                  last_idx <= line_base + (LINE_BYTES - 12'd1);
                end else begin
                  state <= S_DONE;
                end
              end
              default: state <= S_DONE;
            endcase
          end
        end
        S_FILL: begin
          if (!cpu_req) begin
            if (idx == last_idx) state <= S_DONE;
            else                 idx   <= idx + 12'd1;
          end
        end
        S_RD: begin
          if (!cpu_req) begin
            state    <= S_WR;
            wr_first <= 1'b1;
          end
        end
        S_WR: begin
          // Read data is only live on the first WR cycle; capture it even if
          // the write itself is stalled.
          if (wr_first) begin
            hold     <= vram_rdata;
            wr_first <= 1'b0;
          end
          if (!cpu_req) begin
            idx   <= idx + 12'd1;
            state <= (idx == SCROLL_LAST) ? S_FILL : S_RD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake and status flags
  always_comb begin
    cmd_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
  end

  // VRAM port drive; the engine never writes in a cycle the CPU owns the port
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    vram_address = '0;
    vram_wdata   = '0;
    vram_we      = 1'b0;
    case (state)
      S_FILL: begin
        vram_address = idx;
        vram_wdata   = idx[0] ? fill_attr : fill_char;
        vram_we      = !cpu_req;
      end
      S_RD: begin
        vram_address = idx + LINE_BYTES;
      end
      S_WR: begin
        vram_address = idx;
        vram_wdata   = wr_first ? vram_rdata : hold;
        vram_we      = !cpu_req;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_text_blitter.sv
// Directed bench for text_blitter with a behavioural synchronous VRAM.
module tb_text_blitter;

  logic        CLK25;
  logic        RESET_N;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_line;
  logic [7:0]  cmd_char;
  logic [7:0]  cmd_attr;
  logic        busy;
  logic        done;
  logic        cpu_req;
  logic [11:0] vram_address;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [7:0]  vram_rdata;

  text_blitter dut (
    .CLK25        (CLK25),
    .RESET_N      (RESET_N),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_line     (cmd_line),
    .cmd_char     (cmd_char),
    .cmd_attr     (cmd_attr),
    .busy         (busy),
    .done         (done),
    .cpu_req      (cpu_req),
    .vram_address (vram_address),
    .vram_wdata   (vram_wdata),
    .vram_we      (vram_we),
    .vram_rdata   (vram_rdata)
  );

  initial CLK25 = 1'b0;
  always #20 CLK25 = ~CLK25;

  logic [7:0] mem     [0:4095];
  logic [7:0] ref_mem [0:4095];
  bit         load_mode;

  // Synchronous VRAM; a CPU-owned cycle returns junk on the read port
  always @(posedge CLK25) begin
    if (load_mode) begin
      for (int k = 0; k < 4096; k++) mem[k] <= 8'(k);
    end else if (vram_we) begin
      mem[vram_address] <= vram_wdata;
    end
    vram_rdata <= cpu_req ? 8'($urandom) : mem[vram_address];
  end

  int total = 0;
  int bad   = 0;
  int n_cyc, n_we, n_stall, n_viol, n_ready_hi;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_mem(input string tag);
    int nb = 0;
    for (int k = 0; k < 4096; k++) if (mem[k] !== ref_mem[k]) nb++;
    check(tag, nb, 0);
  endtask

  task automatic exp_load();
    for (int k = 0; k < 4096; k++) ref_mem[k] = 8'(k);
  endtask

  task automatic exp_fill(input int lo, input int hi, input logic [7:0] c, input logic [7:0] a);
    for (int k = lo; k <= hi; k++) ref_mem[k] = (k % 2 == 1) ? a : c;
  endtask

  task automatic exp_scroll(input logic [7:0] c, input logic [7:0] a);
    for (int k = 0; k < 3840; k++) ref_mem[k] = ref_mem[k + 160];
    exp_fill(3840, 3999, c, a);
  endtask

  task automatic load_pattern();
    load_mode = 1'b1;
    @(posedge CLK25); #1;
    load_mode = 1'b0;
    exp_load();
  endtask

  // Issue one command at edge 0, run until done, return in cycle N+1 (+#1)
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] line,
                         input logic [7:0] ch, input logic [7:0] at,
                         input bit stall, input bit hold_valid);
    bit fin = 0;
    n_cyc = 0; n_we = 0; n_stall = 0; n_viol = 0; n_ready_hi = 0;
    cmd_op = op; cmd_line = line; cmd_char = ch; cmd_attr = at;
    cmd_valid = 1'b1;
    @(posedge CLK25); #1;
    if (hold_valid) begin
      cmd_op = 2'd2; cmd_line = 5'd0; cmd_char = 8'hAA; cmd_attr = 8'hBB;
    end else begin
      cmd_valid = 1'b0;
    end
    while (!fin && n_cyc < 20000) begin
      cpu_req = stall ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge CLK25);
      n_cyc++;
      if (vram_we) n_we++;
      if (vram_we && cpu_req) n_viol++;
      if (busy && !done && cpu_req) n_stall++;
      if (cmd_ready) n_ready_hi++;
      if (done) begin
        fin = 1;
        cmd_valid = 1'b0;
        cpu_req = 1'b0;
      end
      @(posedge CLK25); #1;
    end
    check("cmd_timeout", 32'(fin), 1);
  endtask

  initial begin
    RESET_N = 1'b0; cmd_valid = 1'b0; cpu_req = 1'b0; load_mode = 1'b0;
    cmd_op = '0; cmd_line = '0; cmd_char = '0; cmd_attr = '0;
    #50;
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_we",    32'(vram_we), 0);
    check("rst_addr",  32'(vram_address), 0);
    check("rst_wdata", 32'(vram_wdata), 0);
    @(posedge CLK25); #1;
    RESET_N = 1'b1;
    @(posedge CLK25); #1;

    // Unstalled scroll on byte k = k[7:0]
    load_pattern();
    run_cmd(2'd1, 5'd0, 8'h41, 8'h07, 1'b0, 1'b0);
    exp_scroll(8'h41, 8'h07);
    check("scroll_latency", n_cyc, 7841);
    check("scroll_writes", n_we, 4000);
    check("scroll_ready_after", 32'(cmd_ready), 1);
    check_mem("scroll_mem");

    // Same scroll with 50% random CPU stalls
    load_pattern();
    run_cmd(2'd1, 5'd0, 8'h41, 8'h07, 1'b1, 1'b0);
    exp_scroll(8'h41, 8'h07);
    check("stall_latency", n_cyc, 32'(7841 + n_stall));
    check("stall_seen", 32'(n_stall > 100), 1);
    check("stall_we_under_cpu", n_viol, 0);
    check("stall_writes", n_we, 4000);
    check_mem("stall_mem");

    // Full clear
    run_cmd(2'd0, 5'd0, 8'h20, 8'h17, 1'b0, 1'b0);
    exp_fill(0, 3999, 8'h20, 8'h17);
    check("clear_latency", n_cyc, 4001);
    check("clear_writes", n_we, 4000);
    check_mem("clear_mem");

    // Fill the last row, then an out-of-range row
    run_cmd(2'd2, 5'd24, 8'h2E, 8'h70, 1'b0, 1'b0);
    exp_fill(3840, 3999, 8'h2E, 8'h70);
    check("fill24_latency", n_cyc, 161);
    check("fill24_writes", n_we, 160);
    check_mem("fill24_mem");

    run_cmd(2'd2, 5'd25, 8'h99, 8'h99, 1'b0, 1'b0);
    check("fill25_latency", n_cyc, 1);
    check("fill25_writes", n_we, 0);
    check_mem("fill25_mem");

    // Reserved op
    run_cmd(2'd3, 5'd0, 8'h99, 8'h99, 1'b0, 1'b0);
    check("op3_latency", n_cyc, 1);
    check("op3_writes", n_we, 0);
    check("op3_ready_after", 32'(cmd_ready), 1);

    // Clear with cmd_valid held high carrying a different command
    run_cmd(2'd0, 5'd0, 8'h30, 8'h1F, 1'b0, 1'b1);
    exp_fill(0, 3999, 8'h30, 8'h1F);
    check("hold_latency", n_cyc, 4001);
    check("hold_ready_low", n_ready_hi, 0);
    check("hold_ready_after", 32'(cmd_ready), 1);
    @(posedge CLK25); #1;
    check("hold_no_accept", 32'(busy), 0);
    check_mem("hold_mem");

    // Reset in cycle 2000 of a clear
    cmd_op = 2'd0; cmd_line = '0; cmd_char = 8'h55; cmd_attr = 8'hAA;
    cmd_valid = 1'b1;
    @(posedge CLK25); #1;
    cmd_valid = 1'b0;
    repeat (1999) @(posedge CLK25);
    #1;
    check("abort_we_before", 32'(vram_we), 1);
    check("abort_addr_before", 32'(vram_address), 1999);
    RESET_N = 1'b0;
    #1;
    check("abort_we_async", 32'(vram_we), 0);
    check("abort_busy_async", 32'(busy), 0);
    @(posedge CLK25); #1;
    RESET_N = 1'b1;
    exp_fill(0, 1998, 8'h55, 8'hAA);
    check("abort_ready", 32'(cmd_ready), 1);
    check_mem("abort_mem");

    run_cmd(2'd2, 5'd3, 8'h61, 8'h62, 1'b0, 1'b0);
    exp_fill(480, 639, 8'h61, 8'h62);
    check("post_abort_latency", n_cyc, 161);
    check_mem("post_abort_mem");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
